wbm_txn_sched: RTL and testbench
================================

// Module: wbm_txn_sched
// PURPOSE
// - Round-robin scheduler sharing one Opal Kelly -> Wishbone single-transaction master among NUM_REQ requesters.
// - Each requester posts one read or write (addr, wdata, we) at a time.
// - Grants the master, pulses its single-rd/wr trigger, holds addr/data stable until done.
// - Captures read data one cycle after done; returns ack or err to the owner.
// - Cycle watchdog aborts hung slaves.
// PARAMETERS
// NUM_REQ      4    number of requesters, 2..8
// TIMEOUT_CYC  256  cycles allowed in WAIT before abort; 0 = watchdog disabled
// PORTS
// wb_clk_i         in   1            Wishbone clock
// wb_rst_ni        in   1            async reset, active-low
// req_i            in   NUM_REQ      request level; held until ack_o/err_o for that index
// we_i             in   NUM_REQ      1 = write, 0 = read; valid with req_i
// addr_i           in   NUM_REQ*16   per-requester address; slice k = [16k+15:16k]
// wdata_i          in   NUM_REQ*16   per-requester write data, same slicing
// gnt_o            out  NUM_REQ      one-hot owner, high from ISSUE through CAPT
// ack_o            out  NUM_REQ      1-cycle completion pulse to owner
// err_o            out  NUM_REQ      1-cycle timeout pulse to owner
// rdata_o          out  16           read data; valid with ack_o, held until next read capture
// m_trg_sngl_rd_o  out  1            1-cycle single-read trigger to master
// m_trg_sngl_wr_o  out  1            1-cycle single-write trigger to master
// m_addr_o         out  16           address to master; held ISSUE..CAPT
// m_data_o         out  16           write data to master; held ISSUE..CAPT
// m_data_i         in   16           master single-read data (updates cycle after done)
// m_done_i         in   1            master transaction-done strobe
// m_busy_i         in   1            master cycle in progress
// m_abort_o        out  1            1-cycle pulse; ORed into master reset on timeout
// sched_busy_o     out  1            state != IDLE
// BEHAVIOUR
// - Reset (async, wb_rst_ni=0): state=IDLE.
//   - Every output 0: gnt, ack, err, rdata, triggers, m_addr, m_data, abort, busy.
//   - RR pointer = 0 (index 0 highest priority); watchdog count = 0.
// - FSM: IDLE -> ISSUE -> WAIT -> CAPT -> IDLE; WAIT -> ABORT -> IDLE on timeout.
// - IDLE: when |req_i and !m_busy_i, pick first requesting index at or after pointer (wrapping at NUM_REQ-1 -> 0).
//   - Latch we/addr/wdata of winner into m_addr_o/m_data_o.
//   - Set gnt_o; pointer = winner+1 mod NUM_REQ. Next state ISSUE.
//   - If m_busy_i=1, no grant; stay IDLE.
// - ISSUE (1 cycle): m_trg_sngl_wr_o = we, m_trg_sngl_rd_o = ~we; never both. Clear watchdog. -> WAIT.
// - WAIT: m_done_i=1 -> CAPT.
//   - Else count++; count == TIMEOUT_CYC-1 (TIMEOUT_CYC != 0) -> ABORT.
//   - Done and timeout in the same cycle: done wins.
// - CAPT (1 cycle): ack_o[owner]=1.
//   - If read, rdata_o <= m_data_i (master output settles the cycle after done).
//   - gnt_o cleared on exit. -> IDLE.
// - ABORT (1 cycle): err_o[owner]=1, m_abort_o=1, rdata_o unchanged, gnt_o cleared on exit. -> IDLE.
// - Latency: req seen in IDLE at cycle t -> trigger at t+1; ack_o at (cycle of m_done_i)+1.
//   - Minimum request-to-request spacing is 4 cycles.
// - Requester dropping req_i mid-transaction does not cancel it; ack/err still issued.
// - req_i still high in the cycle after ack_o counts as a new request.
// - m_done_i outside WAIT: ignored. Other requesters are never acked or erred.
// - gnt_o, ack_o, err_o are always one-hot or zero.
// TESTING
// - Single write: req_i=0001, we=1, addr=0x0003, wdata=0xBEEF; done 3 cycles after trigger.
//   -> one m_trg_sngl_wr_o pulse; m_addr_o=0x0003, m_data_o=0xBEEF held; ack_o=0001 once.
// - Single read: req_i=0100, we=0; m_data_i=0x1234 the cycle after done.
//   -> rdata_o=0x1234 with ack_o=0100; no wr trigger.
// - Fairness: req_i=1111 held continuously.
//   -> grants in order 0,1,2,3,0; each index acked once per 4 transactions.
// - Timeout, TIMEOUT_CYC=8, m_done_i never asserted.
//   -> err_o[owner] and m_abort_o pulse 8 cycles after ISSUE; next request proceeds normally.
// - m_busy_i=1 at request time -> no grant until m_busy_i falls.
//   - Done on the final watchdog cycle -> ack, not err.
// - Reset asserted in WAIT -> all outputs 0 immediately; after release req_i=1010 grants index 1 first.

Source files
------------

// File: rtl/wbm_txn_sched.sv
// Round-robin scheduler sharing one single-transaction Wishbone master.
// Ports: req/we/addr/wdata per requester in; gnt/ack/err/rdata out;
// m_trg_*/m_addr/m_data/m_abort drive the master, m_data/done/busy return.
module wbm_txn_sched #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ-1:0]    we_i,
  input  logic [NUM_REQ*16-1:0] addr_i,
  input  logic [NUM_REQ*16-1:0] wdata_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [NUM_REQ-1:0]    ack_o,
  output logic [NUM_REQ-1:0]    err_o,
  output logic [15:0]           rdata_o,
  output logic                  m_trg_sngl_rd_o,
  output logic                  m_trg_sngl_wr_o,
  output logic [15:0]           m_addr_o,
  output logic [15:0]           m_data_o,
  input  logic [15:0]           m_data_i,
  input  logic                  m_done_i,
  input  logic                  m_busy_i,
  output logic                  m_abort_o,
  output logic                  sched_busy_o
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT_CYC < 4) ? 2 : $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);
  localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);
  localparam bit WDOG = (TIMEOUT_CYC != 0);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPT,
    ABORT
  } state_t;

  state_t state, nxt;

  logic [15:0]        addr_a  [NUM_REQ];
  logic [15:0]        wdata_a [NUM_REQ];
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      win;
  logic               found;
  logic               go;
  logic [NUM_REQ-1:0] gnt_q;
  logic               we_q;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_nxt;
  logic               expire;
  logic [15:0]        rdata_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = addr_i[16*g +: 16];
    assign wdata_a[g] = wdata_i[16*g +: 16];
  end

  // first requester at or after the pointer, wrapping
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_i[PW'(j)]) begin
        found = 1'b1;
        win   = PW'(j);
      end
    end
  end

  assign go      = found & ~m_busy_i;
  assign cnt_nxt = cnt + CW'(1);
  assign expire  = WDOG && (cnt_nxt >= LIMIT);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else            state <= nxt;
  end

  always_comb begin
    nxt             = state;
    m_trg_sngl_rd_o = 1'b0;
    m_trg_sngl_wr_o = 1'b0;
    ack_o           = '0;
    err_o           = '0;
    m_abort_o       = 1'b0;
    rdata_o         = rdata_q;
    sched_busy_o    = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (go) nxt = ISSUE;
      end
      ISSUE: begin
        m_trg_sngl_wr_o = we_q;
        m_trg_sngl_rd_o = ~we_q;
        nxt             = WAIT;
      end
      WAIT: begin
        // done beats the watchdog on the same cycle
        if (m_done_i)    nxt = CAPT;
        else if (expire) nxt = ABORT;
      end
      CAPT: begin
        ack_o = gnt_q;
        // master read data settles this cycle; pass it through with ack
        if (!we_q) rdata_o = m_data_i;
        nxt = IDLE;
      end
      ABORT: begin
        err_o     = gnt_q;
        m_abort_o = 1'b1;
        nxt       = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      gnt_q    <= '0;
      we_q     <= 1'b0;
      m_addr_o <= '0;
      m_data_o <= '0;
      ptr      <= '0;
      cnt      <= '0;
      rdata_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            gnt_q    <= NUM_REQ'(1) << win;
            we_q     <= we_i[win];
            m_addr_o <= addr_a[win];
            m_data_o <= wdata_a[win];
            ptr      <= (win == LAST) ? '0 : win + PW'(1);
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (WDOG && !m_done_i) cnt <= cnt_nxt;
        end
        CAPT: begin
          if (!we_q) rdata_q <= m_data_i;
          gnt_q <= '0;
        end
        ABORT: gnt_q <= '0;
        default: ;
      endcase
    end
  end

  assign gnt_o = gnt_q;

endmodule

// File: tb/tb_wbm_txn_sched.sv
// Randomized self-checking bench for wbm_txn_sched (NUM_REQ=4, TIMEOUT_CYC=8).
// A transaction-level model tracks the round-robin pointer and held read data.
module tb_wbm_txn_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, we;
  logic [63:0] addr, wdata;
  logic [15:0] m_rdata;
  logic        m_done, m_busy;
  logic [3:0]  gnt, ack, err;
  logic [15:0] rdata, m_addr, m_data;
  logic        trg_rd, trg_wr, abort, busy;

  int n_chk = 0;
  int n_fail = 0;
  int ptr_m;
  int last_win;
  int acks [4];
  logic [15:0] rdata_m;

  always #5 clk = ~clk;

  wbm_txn_sched #(.NUM_REQ(4), .TIMEOUT_CYC(8)) dut (
    .wb_clk_i        (clk),
    .wb_rst_ni       (rst_n),
    .req_i           (req),
    .we_i            (we),
    .addr_i          (addr),
    .wdata_i         (wdata),
    .gnt_o           (gnt),
    .ack_o           (ack),
    .err_o           (err),
    .rdata_o         (rdata),
    .m_trg_sngl_rd_o (trg_rd),
    .m_trg_sngl_wr_o (trg_wr),
    .m_addr_o        (m_addr),
    .m_data_o        (m_data),
    .m_data_i        (m_rdata),
    .m_done_i        (m_done),
    .m_busy_i        (m_busy),
    .m_abort_o       (abort),
    .sched_busy_o    (busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // round-robin rule: first requesting index at or after the pointer
  function automatic int pick(input logic [3:0] r);
    int k;
    pick = -1;
    for (int i = 0; i < 4; i++) begin
      k = (ptr_m + i) % 4;
      if (pick < 0 && r[k[1:0]]) pick = k;
    end
  endfunction

  // Called during an IDLE cycle; returns at the negedge of the IDLE
  // cycle that follows CAPT, with req still driven to r unless dropped.
  task automatic txn(input logic [3:0] r, input logic [3:0] w,
                     input int dly, input bit drop, input logic [15:0] rd);
    int k;
    logic [3:0] oh;
    logic [15:0] ea, ed;
    logic ew;
    k  = pick(r);
    oh = 4'b0001 << k[1:0];
    ea = 16'(addr >> (16 * k));
    ed = 16'(wdata >> (16 * k));
    ew = w[k[1:0]];
    req = r;
    we  = w;
    step;
    if (drop) req = '0;
    @(negedge clk);
    n_chk++;
    if ({trg_wr, trg_rd, gnt, m_addr, m_data, busy} !==
        {ew, ~ew, oh, ea, ed, 1'b1}) begin
      n_fail++;
      $display("FAIL issue: wr=%b rd=%b gnt=%b a=%h d=%h, want wr=%b rd=%b gnt=%b a=%h d=%h",
               trg_wr, trg_rd, gnt, m_addr, m_data, ew, ~ew, oh, ea, ed);
    end
    for (int c = 1; c <= dly; c++) begin
      step;
      m_rdata = 16'($urandom);
      m_done  = (c == dly);
      @(negedge clk);
      n_chk++;
      if ({trg_wr, trg_rd, ack, err, abort, gnt, m_addr, m_data} !==
          {2'b00, 4'b0000, 4'b0000, 1'b0, oh, ea, ed}) begin
        n_fail++;
        $display("FAIL wait%0d: trg=%b%b ack=%b err=%b abort=%b gnt=%b a=%h d=%h, want gnt=%b a=%h d=%h",
                 c, trg_wr, trg_rd, ack, err, abort, gnt, m_addr, m_data, oh, ea, ed);
      end
    end
    step;
    m_done  = 1'b0;
    m_rdata = rd;
    if (!ew) rdata_m = rd;
    @(negedge clk);
    n_chk++;
    if ({ack, err, abort, gnt, rdata} !== {oh, 4'b0000, 1'b0, oh, rdata_m}) begin
      n_fail++;
      $display("FAIL capt: ack=%b err=%b abort=%b gnt=%b rdata=%h, want ack=%b gnt=%b rdata=%h",
               ack, err, abort, gnt, rdata, oh, oh, rdata_m);
    end
    acks[k[1:0]]++;
    last_win = k;
    ptr_m = (k + 1) % 4;
    step;
    m_rdata = 16'($urandom);
    @(negedge clk);
    n_chk++;
    if ({gnt, ack, err, busy, rdata} !== {4'b0000, 4'b0000, 4'b0000, 1'b0, rdata_m}) begin
      n_fail++;
      $display("FAIL post: gnt=%b ack=%b err=%b busy=%b rdata=%h, want all 0 rdata=%h",
               gnt, ack, err, busy, rdata, rdata_m);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({gnt, ack, err, rdata, trg_rd, trg_wr, m_addr, m_data, abort, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset: gnt=%b ack=%b err=%b rdata=%h a=%h d=%h busy=%b, want 0",
               gnt, ack, err, rdata, m_addr, m_data, busy);
    end
    step;
    rst_n = 1'b1;
    ptr_m = 0;
    rdata_m = '0;
    @(negedge clk);
    n_chk++;
    if ({gnt, busy, trg_rd, trg_wr} !== '0) begin
      n_fail++;
      $display("FAIL reset_rel: gnt=%b busy=%b, want 0", gnt, busy);
    end
  endtask

  task automatic test_single_write;
    addr  = 64'h0;
    wdata = 64'h0;
    addr[15:0]  = 16'h0003;
    wdata[15:0] = 16'hBEEF;
    txn(4'b0001, 4'b0001, 3, 1'b0, 16'h0000);
    req = '0;
    n_chk++;
    if (last_win !== 0 || acks[0] !== 1) begin
      n_fail++;
      $display("FAIL single_write: winner=%0d acks=%0d, want 0 and 1", last_win, acks[0]);
    end
  endtask

  task automatic test_single_read;
    addr[47:32] = 16'h00A4;
    txn(4'b0100, 4'b0000, 2, 1'b0, 16'h1234);
    req = '0;
    repeat (3) begin
      step;
      m_rdata = 16'($urandom);
    end
    @(negedge clk);
    n_chk++;
    if (rdata !== 16'h1234 || last_win !== 2) begin
      n_fail++;
      $display("FAIL single_read: rdata=%h winner=%0d, want 1234 and 2", rdata, last_win);
    end
  endtask

  task automatic test_fairness;
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    ptr_m = 0;
    rdata_m = '0;
    for (int i = 0; i < 4; i++) acks[i] = 0;
    addr  = {$urandom, $urandom};
    wdata = {$urandom, $urandom};
    for (int i = 0; i < 5; i++) begin
      txn(4'b1111, 4'($urandom), $urandom_range(1, 7), 1'b0, 16'($urandom));
      n_chk++;
      if (last_win !== i % 4) begin
        n_fail++;
        $display("FAIL fair_order: txn %0d winner=%0d, want %0d", i, last_win, i % 4);
      end
      if (i == 3) begin
        n_chk++;
        if (acks[0] !== 1 || acks[1] !== 1 || acks[2] !== 1 || acks[3] !== 1) begin
          n_fail++;
          $display("FAIL fair_acks: %0d %0d %0d %0d, want 1 1 1 1",
                   acks[0], acks[1], acks[2], acks[3]);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_busy;
    m_busy = 1'b1;
    req = 4'b0010;
    repeat (3) begin
      step;
      @(negedge clk);
      n_chk++;
      if ({gnt, busy, trg_rd, trg_wr} !== '0) begin
        n_fail++;
        $display("FAIL busy_hold: gnt=%b busy=%b trg=%b%b, want 0", gnt, busy, trg_wr, trg_rd);
      end
    end
    m_busy = 1'b0;
    txn(4'b0010, 4'b0010, 4, 1'b1, 16'h0);
    req = '0;
  endtask

  task automatic test_timeout;
    int k;
    logic [3:0] r, oh;
    r  = 4'($urandom_range(1, 15));
    k  = pick(r);
    oh = 4'b0001 << k[1:0];
    req = r;
    we  = 4'($urandom);
    step;
    req = '0;
    @(negedge clk);
    n_chk++;
    if ((trg_rd ^ trg_wr) !== 1'b1 || gnt !== oh) begin
      n_fail++;
      $display("FAIL to_issue: trg=%b%b gnt=%b, want one trigger gnt=%b", trg_wr, trg_rd, gnt, oh);
    end
    for (int c = 1; c <= 8; c++) begin
      step;
      m_rdata = 16'($urandom);
      @(negedge clk);
      n_chk++;
      if (c < 8) begin
        if ({err, abort, ack, gnt} !== {4'b0000, 1'b0, 4'b0000, oh}) begin
          n_fail++;
          $display("FAIL to_early%0d: err=%b abort=%b ack=%b gnt=%b, want gnt=%b only",
                   c, err, abort, ack, gnt, oh);
        end
      end else begin
        if ({err, abort, ack, gnt, rdata} !== {oh, 1'b1, 4'b0000, oh, rdata_m}) begin
          n_fail++;
          $display("FAIL to_abort: err=%b abort=%b ack=%b gnt=%b rdata=%h, want err=%b abort=1 rdata=%h",
                   err, abort, ack, gnt, rdata, oh, rdata_m);
        end
      end
    end
    ptr_m = (k + 1) % 4;
    step;
    @(negedge clk);
    n_chk++;
    if ({gnt, err, abort, busy} !== '0) begin
      n_fail++;
      $display("FAIL to_after: gnt=%b err=%b abort=%b busy=%b, want 0", gnt, err, abort, busy);
    end
    txn(4'($urandom_range(1, 15)), 4'($urandom), 2, 1'b1, 16'($urandom));
    req = '0;
  endtask

  task automatic test_done_final;
    txn(4'($urandom_range(1, 15)), 4'b0000, 7, 1'b1, 16'h5A5A);
    req = '0;
  endtask

  task automatic test_done_idle;
    m_done = 1'b1;
    repeat (2) begin
      step;
      @(negedge clk);
      n_chk++;
      if ({ack, err, busy} !== '0) begin
        n_fail++;
        $display("FAIL done_idle: ack=%b err=%b busy=%b, want 0", ack, err, busy);
      end
    end
    m_done = 1'b0;
  endtask

  task automatic test_reset_wait;
    req = 4'b1000;
    we  = 4'($urandom);
    step;
    step;
    #2;
    rst_n = 1'b0;
    req = '0;
    #1;
    n_chk++;
    if ({gnt, ack, err, rdata, trg_rd, trg_wr, m_addr, m_data, abort, busy} !== '0) begin
      n_fail++;
      $display("FAIL rst_wait: gnt=%b rdata=%h a=%h d=%h busy=%b, want 0",
               gnt, rdata, m_addr, m_data, busy);
    end
    step;
    rst_n = 1'b1;
    ptr_m = 0;
    rdata_m = '0;
    txn(4'b1010, 4'($urandom), 3, 1'b0, 16'($urandom));
    req = '0;
    n_chk++;
    if (last_win !== 1) begin
      n_fail++;
      $display("FAIL rst_wait_gnt: winner=%0d, want 1", last_win);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 25; i++) begin
      addr  = {$urandom, $urandom};
      wdata = {$urandom, $urandom};
      txn(4'($urandom_range(1, 15)), 4'($urandom), $urandom_range(1, 7),
          1'($urandom), 16'($urandom));
      req = '0;
      repeat ($urandom_range(0, 2)) step;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = '0;
    we      = '0;
    addr    = '0;
    wdata   = '0;
    m_rdata = '0;
    m_done  = 1'b0;
    m_busy  = 1'b0;
    ptr_m   = 0;
    last_win = -1;
    rdata_m = '0;
    for (int i = 0; i < 4; i++) acks[i] = 0;
    test_reset;
    test_single_write;
    test_single_read;
    test_fairness;
    test_busy;
    test_timeout;
    test_done_final;
    test_done_idle;
    test_reset_wait;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
